// File: rtl/jk_excite_seq.sv
// rtl/jk_excite_seq.sv - converts a desired state into JK excitation and applies it to an internal JK register
// Parallel mode applies all bits in one cycle; serial mode walks one bit per cycle, LSB first.
module jk_excite_seq #(
   parameter int WIDTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [WIDTH-1:0]             target,
   input  logic                         mode,
   input  logic                         hold,
   output logic [WIDTH-1:0]             j_out,
   output logic [WIDTH-1:0]             k_out,
   output logic [WIDTH-1:0]             q,
   output logic [WIDTH-1:0]             qb,
   output logic                         done,
   output logic                         match,
   output logic [$clog2(WIDTH+1)-1:0]   chg_cnt
);

   localparam int CW = $clog2(WIDTH+1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, APPLY, CHECK} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             mode_q, mode_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [WIDTH-1:0] j_all, k_all, sel, j_v, k_v, diff;
   logic [CW-1:0]    pop;

   always_comb begin
      diff = target ^ q_q;
      pop  = '0;
      for (int i = 0; i < WIDTH; i++) begin
         pop = pop + CW'(diff[i]);
      end
   end

   // Inverse JK next-state function: set only on 0->1, clear only on 1->0, never toggle.
   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      mode_d  = mode_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      j_all   = tgt_q & ~q_q;
      k_all   = ~tgt_q & q_q;
      sel     = mode_q ? (WIDTH'(1) << idx_q) : '1;
      j_v     = '0;
      k_v     = '0;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               tgt_d   = target;
               mode_d  = mode;
               cnt_d   = pop;
               idx_d   = '0;
               state_d = APPLY;
            end
         end
         APPLY: begin
            if (!hold) begin
               j_v = j_all & sel;
               k_v = k_all & sel;
            end
            if (!mode_q || idx_q == IW'(WIDTH-1)) begin
               state_d = CHECK;
            end else begin
               idx_d = idx_q + IW'(1);
            end
         end
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
      q_d = (j_v & ~q_q) | (~k_v & q_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         q_q     <= '0;
         tgt_q   <= '0;
         mode_q  <= 1'b0;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         tgt_q   <= tgt_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   assign req_ready = (state_q == IDLE);
   assign done      = (state_q == CHECK);
   assign match     = (state_q == CHECK) && (q_q == tgt_q);
   assign j_out     = j_v;
   assign k_out     = k_v;
   assign q         = q_q;
   assign qb        = ~q_q;
   assign chg_cnt   = cnt_q;

endmodule

// File: tb/tb_jk_excite_seq.sv
// tb/tb_jk_excite_seq.sv - self-checking bench for jk_excite_seq
// Directed scenarios plus randomized requests against a bit-level transition model.
module tb_jk_excite_seq;
   localparam int W = 4;

   logic       clk = 1'b0;
   logic       rst_n, req_valid, mode, hold;
   logic [3:0] target;
   logic       req_ready, done, match;
   logic [3:0] j_out, k_out, q, qb;
   logic [2:0] chg_cnt;

   int checks = 0;
   int errors = 0;

   logic [3:0] mq;
   logic [3:0] obs_j[32], obs_k[32], obs_q[32];
   logic [3:0] obs_qf, obs_qbf;
   int         obs_lat;
   logic       obs_match, obs_rdy_acc, obs_rdy_busy, obs_rdy_chk, obs_done_after, obs_rdy_after;
   logic [2:0] obs_cnt;

   logic [3:0] exp_j[32], exp_k[32], exp_q[32];
   int         exp_lat;
   logic       exp_match;
   logic [2:0] exp_cnt;

   jk_excite_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .target(target), .mode(mode), .hold(hold), .j_out(j_out), .k_out(k_out),
      .q(q), .qb(qb), .done(done), .match(match), .chg_cnt(chg_cnt)
   );

   always #5 clk = ~clk;

   // Drives one request from IDLE and records what the DUT shows; called at posedge+1.
   task automatic do_req(input logic [3:0] t, input logic m, input logic [31:0] hm);
      obs_rdy_acc = req_ready;
      req_valid = 1'b1; target = t; mode = m; hold = 1'b0;
      @(posedge clk); #1;
      req_valid = 1'b0; target = 4'($urandom); mode = 1'($urandom);
      obs_lat = -1; obs_rdy_busy = 1'b0;
      for (int c = 0; c < 20; c++) begin
         if (done === 1'b1) begin
            obs_lat = c + 1; obs_match = match; obs_cnt = chg_cnt;
            obs_rdy_chk = req_ready; obs_qf = q; obs_qbf = qb;
            break;
         end
         hold = hm[c]; #1;
         obs_j[c] = j_out; obs_k[c] = k_out; obs_rdy_busy = obs_rdy_busy | req_ready;
         @(posedge clk); #1;
         hold = 1'b0; obs_q[c] = q;
      end
      @(posedge clk); #1;
      obs_done_after = done; obs_rdy_after = req_ready;
   endtask

   // Reference: each apply cycle moves selected, non-held bits to their target value.
   task automatic model_req(input logic [3:0] t, input logic m, input logic [31:0] hm);
      logic [3:0] cur;
      int n;
      cur = mq;
      n = m ? W : 1;
      exp_cnt = 3'($countones(t ^ cur));
      exp_lat = n + 1;
      for (int c = 0; c < n; c++) begin
         exp_j[c] = 4'b0; exp_k[c] = 4'b0;
         for (int b = 0; b < W; b++) begin
            if (!hm[c] && (!m || b == c) && cur[b] != t[b]) begin
               if (t[b]) exp_j[c][b] = 1'b1;
               else      exp_k[c][b] = 1'b1;
            end
         end
         for (int b = 0; b < W; b++) begin
            if (exp_j[c][b]) cur[b] = 1'b1;
            if (exp_k[c][b]) cur[b] = 1'b0;
         end
         exp_q[c] = cur;
      end
      exp_match = (cur == t);
      mq = cur;
   endtask

   task automatic test_reset;
      rst_n = 1'b1; req_valid = 1'b0; mode = 1'b0; hold = 1'b0; target = 4'h0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (q !== 4'h0)       begin errors++; $display("FAIL rst_q got %b exp 0000", q); end
      checks++; if (qb !== 4'hF)      begin errors++; $display("FAIL rst_qb got %b exp 1111", qb); end
      checks++; if (done !== 1'b0 || match !== 1'b0) begin errors++; $display("FAIL rst_done_match got %b%b exp 00", done, match); end
      checks++; if (chg_cnt !== 3'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", chg_cnt); end
      checks++; if (j_out !== 4'h0 || k_out !== 4'h0) begin errors++; $display("FAIL rst_jk got %b/%b exp 0000/0000", j_out, k_out); end
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", req_ready); end
   endtask

   task automatic test_parallel;
      do_req(4'b1010, 1'b0, 32'h0);
      checks++; if (obs_rdy_acc !== 1'b1) begin errors++; $display("FAIL p1_ready got %b exp 1", obs_rdy_acc); end
      checks++; if (obs_j[0] !== 4'b1010 || obs_k[0] !== 4'b0000) begin errors++; $display("FAIL p1_jk got %b/%b exp 1010/0000", obs_j[0], obs_k[0]); end
      checks++; if (obs_rdy_busy !== 1'b0) begin errors++; $display("FAIL p1_busy_ready got %b exp 0", obs_rdy_busy); end
      checks++; if (obs_lat !== 2) begin errors++; $display("FAIL p1_latency got %0d exp 2", obs_lat); end
      checks++; if (obs_qf !== 4'b1010 || obs_qbf !== 4'b0101) begin errors++; $display("FAIL p1_q got %b/%b exp 1010/0101", obs_qf, obs_qbf); end
      checks++; if (obs_match !== 1'b1 || obs_cnt !== 3'd2) begin errors++; $display("FAIL p1_match_cnt got %b/%0d exp 1/2", obs_match, obs_cnt); end
      checks++; if (obs_rdy_chk !== 1'b0 || obs_done_after !== 1'b0 || obs_rdy_after !== 1'b1) begin errors++; $display("FAIL p1_check_phase got %b%b%b exp 001", obs_rdy_chk, obs_done_after, obs_rdy_after); end
      do_req(4'b0110, 1'b0, 32'h0);
      checks++; if (obs_j[0] !== 4'b0100 || obs_k[0] !== 4'b1000) begin errors++; $display("FAIL p2_jk got %b/%b exp 0100/1000", obs_j[0], obs_k[0]); end
      checks++; if (obs_qf !== 4'b0110 || obs_lat !== 2) begin errors++; $display("FAIL p2_q_lat got %b/%0d exp 0110/2", obs_qf, obs_lat); end
      checks++; if (obs_match !== 1'b1 || obs_cnt !== 3'd2) begin errors++; $display("FAIL p2_match_cnt got %b/%0d exp 1/2", obs_match, obs_cnt); end
   endtask

   task automatic test_serial;
      logic [3:0] ej[4], ek[4], eq[4];
      ej = '{4'b0001, 4'b0000, 4'b0000, 4'b1000};
      ek = '{4'b0000, 4'b0010, 4'b0100, 4'b0000};
      eq = '{4'b0111, 4'b0101, 4'b0001, 4'b1001};
      do_req(4'b1001, 1'b1, 32'h0);
      for (int c = 0; c < 4; c++) begin
         checks++; if (obs_j[c] !== ej[c] || obs_k[c] !== ek[c]) begin errors++; $display("FAIL s_jk[%0d] got %b/%b exp %b/%b", c, obs_j[c], obs_k[c], ej[c], ek[c]); end
         checks++; if (obs_q[c] !== eq[c]) begin errors++; $display("FAIL s_q[%0d] got %b exp %b", c, obs_q[c], eq[c]); end
      end
      checks++; if (obs_lat !== 5) begin errors++; $display("FAIL s_latency got %0d exp 5", obs_lat); end
      checks++; if (obs_match !== 1'b1 || obs_cnt !== 3'd4) begin errors++; $display("FAIL s_match_cnt got %b/%0d exp 1/4", obs_match, obs_cnt); end
      checks++; if (obs_rdy_busy !== 1'b0) begin errors++; $display("FAIL s_busy_ready got %b exp 0", obs_rdy_busy); end
   endtask

   task automatic test_equal;
      do_req(4'b1001, 1'b0, 32'h0);
      checks++; if (obs_j[0] !== 4'b0 || obs_k[0] !== 4'b0) begin errors++; $display("FAIL eq_jk got %b/%b exp 0000/0000", obs_j[0], obs_k[0]); end
      checks++; if (obs_cnt !== 3'd0 || obs_match !== 1'b1 || obs_lat !== 2) begin errors++; $display("FAIL eq_cnt_match_lat got %0d/%b/%0d exp 0/1/2", obs_cnt, obs_match, obs_lat); end
   endtask

   task automatic test_hold;
      do_req(4'b0000, 1'b0, 32'h0);
      checks++; if (obs_qf !== 4'b0000) begin errors++; $display("FAIL h_setup_q got %b exp 0000", obs_qf); end
      do_req(4'b1111, 1'b0, 32'h1);
      checks++; if (obs_j[0] !== 4'b0 || obs_k[0] !== 4'b0) begin errors++; $display("FAIL hp_jk got %b/%b exp 0000/0000", obs_j[0], obs_k[0]); end
      checks++; if (obs_qf !== 4'b0000 || obs_lat !== 2) begin errors++; $display("FAIL hp_q_lat got %b/%0d exp 0000/2", obs_qf, obs_lat); end
      checks++; if (obs_match !== 1'b0 || obs_cnt !== 3'd4) begin errors++; $display("FAIL hp_match_cnt got %b/%0d exp 0/4", obs_match, obs_cnt); end
      do_req(4'b1111, 1'b1, 32'h2);
      checks++; if (obs_j[1] !== 4'b0) begin errors++; $display("FAIL hs_j1 got %b exp 0000", obs_j[1]); end
      checks++; if (obs_q[1] !== 4'b0001 || obs_qf !== 4'b1101) begin errors++; $display("FAIL hs_q got %b/%b exp 0001/1101", obs_q[1], obs_qf); end
      checks++; if (obs_lat !== 5 || obs_match !== 1'b0) begin errors++; $display("FAIL hs_lat_match got %0d/%b exp 5/0", obs_lat, obs_match); end
   endtask

   task automatic test_reset_mid;
      req_valid = 1'b1; target = 4'b0010; mode = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++; if (q !== 4'b1100) begin errors++; $display("FAIL rm_partial_q got %b exp 1100", q); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (q !== 4'b0000 || qb !== 4'b1111) begin errors++; $display("FAIL rm_q got %b/%b exp 0000/1111", q, qb); end
      checks++; if (req_ready !== 1'b1 || j_out !== 4'b0 || k_out !== 4'b0) begin errors++; $display("FAIL rm_ready_jk got %b/%b/%b exp 1/0000/0000", req_ready, j_out, k_out); end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL rm_no_done[%0d] got %b exp 0", i, done); end
      end
      rst_n = 1'b1;
      mq = 4'b0000;
      do_req(4'b0101, 1'b1, 32'h0);
      checks++; if (obs_rdy_acc !== 1'b1 || obs_lat !== 5) begin errors++; $display("FAIL rm_after_rdy_lat got %b/%0d exp 1/5", obs_rdy_acc, obs_lat); end
      checks++; if (obs_qf !== 4'b0101 || obs_match !== 1'b1 || obs_cnt !== 3'd2) begin errors++; $display("FAIL rm_after_q got %b/%b/%0d exp 0101/1/2", obs_qf, obs_match, obs_cnt); end
      mq = 4'b0101;
   endtask

   // req_valid stays high; only the target present at an IDLE edge is taken.
   task automatic test_back_to_back;
      int busy;
      logic [3:0] acc, prev;
      busy = 0; acc = mq; prev = mq;
      for (int cyc = 0; cyc < 60; cyc++) begin
         checks++; if (req_ready !== (busy == 0)) begin errors++; $display("FAIL bb_ready[%0d] got %b exp %b", cyc, req_ready, busy == 0); end
         checks++; if (done !== (busy == 1)) begin errors++; $display("FAIL bb_done[%0d] got %b exp %b", cyc, done, busy == 1); end
         if (busy == 1) begin
            checks++; if (q !== acc || match !== 1'b1) begin errors++; $display("FAIL bb_q[%0d] got %b/%b exp %b/1", cyc, q, match, acc); end
            checks++; if (chg_cnt !== 3'($countones(acc ^ prev))) begin errors++; $display("FAIL bb_cnt[%0d] got %0d exp %0d", cyc, chg_cnt, $countones(acc ^ prev)); end
            mq = acc;
         end
         req_valid = (cyc < 40); target = 4'($urandom); mode = 1'($urandom);
         @(posedge clk);
         if (busy == 0 && req_valid) begin
            prev = mq; acc = target; busy = (mode ? W : 1) + 1;
         end else if (busy > 0) begin
            busy--;
         end
         #1;
      end
      req_valid = 1'b0;
   endtask

   task automatic test_random;
      logic [3:0] t;
      logic m;
      logic [31:0] hm;
      for (int n = 0; n < 40; n++) begin
         t = 4'($urandom); m = 1'($urandom);
         hm = 32'h0;
         for (int c = 0; c < W; c++) hm[c] = ($urandom_range(0, 3) == 0);
         model_req(t, m, hm);
         do_req(t, m, hm);
         checks++; if (obs_lat !== exp_lat) begin errors++; $display("FAIL rnd_lat[%0d] got %0d exp %0d", n, obs_lat, exp_lat); end
         for (int c = 0; c < exp_lat - 1; c++) begin
            checks++; if (obs_j[c] !== exp_j[c] || obs_k[c] !== exp_k[c]) begin errors++; $display("FAIL rnd_jk[%0d][%0d] got %b/%b exp %b/%b", n, c, obs_j[c], obs_k[c], exp_j[c], exp_k[c]); end
            checks++; if (obs_q[c] !== exp_q[c]) begin errors++; $display("FAIL rnd_q[%0d][%0d] got %b exp %b", n, c, obs_q[c], exp_q[c]); end
         end
         checks++; if (obs_match !== exp_match || obs_cnt !== exp_cnt) begin errors++; $display("FAIL rnd_match_cnt[%0d] got %b/%0d exp %b/%0d", n, obs_match, obs_cnt, exp_match, exp_cnt); end
         checks++; if (obs_rdy_busy !== 1'b0 || obs_done_after !== 1'b0 || obs_rdy_after !== 1'b1) begin errors++; $display("FAIL rnd_handshake[%0d] got %b%b%b exp 001", n, obs_rdy_busy, obs_done_after, obs_rdy_after); end
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   initial begin
      mq = 4'b0000;
      test_reset;
      test_parallel;
      test_serial;
      test_equal;
      test_hold;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
